// File: rtl/mem_word_loader.sv
// mem_word_loader: fetches one DATAWIDTH-bit word from a BYTEWIDTH-wide memory
// as two byte reads over a req/ack handshake. It then presents the word to a
// Register stage with a one-cycle active-low load strobe.
//
// Memory handshake: while mem_req is high, mem_addr is held stable. A byte
// transfer happens on the rising edge where mem_req=1 and mem_ack=1, and
// mem_rdata is captured on that same edge. mem_ack is ignored while mem_req=0.
// mem_req drops for at least one cycle (GAP) between the two byte requests.
//
// The word width must equal 2*BYTEWIDTH, because the word is exactly the
// concatenation of the two fetched bytes.
module mem_word_loader #(
    parameter int DATAWIDTH     = 16,
    parameter int BYTEWIDTH     = 8,
    parameter int ADDRWIDTH     = 16,
    parameter int LITTLE_ENDIAN = 1,
    parameter int TIMEOUT       = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDRWIDTH-1:0] addr_in,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic                 mem_req,
    output logic [ADDRWIDTH-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [BYTEWIDTH-1:0] mem_rdata,
    output logic [DATAWIDTH-1:0] reg_data,
    output logic                 reg_load,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH0 = 3'd1,
        GAP    = 3'd2,
        FETCH1 = 3'd3,
        LOAD   = 3'd4,
        DONE   = 3'd5
    } state_t;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_t               state;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [BYTEWIDTH-1:0] byte0;
    logic [CW-1:0]        cnt;

    // The state register is visible directly, so checkers can observe the sequencing.
    assign state_dbg = state;

    // Controller: sequences the two byte fetches, assembles the word, and pulses load and done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
            reg_data <= '0;
            reg_load <= 1'b1;
            addr_q   <= '0;
            byte0    <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        addr_q   <= addr_in;
                        mem_addr <= addr_in;
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        cnt      <= '0;
                        state    <= FETCH0;
                    end
                end
                FETCH0: begin
                    // An ack on the expiry cycle still completes the byte.
                    if (mem_ack) begin
                        byte0    <= mem_rdata;
                        mem_req  <= 1'b0;
                        mem_addr <= addr_q + ADDRWIDTH'(1);
                        state    <= GAP;
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    mem_req <= 1'b1;
                    cnt     <= '0;
                    state   <= FETCH1;
                end
                FETCH1: begin
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        reg_load <= 1'b0;
                        if (LITTLE_ENDIAN != 0) begin
                            reg_data <= {mem_rdata, byte0};
                        end else begin
                            reg_data <= {byte0, mem_rdata};
                        end
                        state <= LOAD;
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LOAD: begin
                    reg_load <= 1'b1;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_word_loader.sv
// Bench for mem_word_loader: a little-endian and a big-endian instance share
// one memory responder and one stimulus stream. Expectations come from a
// byte-array memory and the transaction rules, and are queued per transaction.
module tb_mem_word_loader;

    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] addr_in;
    logic        mem_ack;
    logic [7:0]  mem_rdata;

    logic        busy_le, done_le, err_le, req_le, rl_le;
    logic [15:0] maddr_le, rd_le;
    logic [2:0]  st_le;
    logic        busy_be, done_be, err_be, req_be, rl_be;
    logic [15:0] maddr_be, rd_be;
    logic [2:0]  st_be;

    mem_word_loader #(.DATAWIDTH(16), .BYTEWIDTH(8), .ADDRWIDTH(16),
                      .LITTLE_ENDIAN(1), .TIMEOUT(TIMEOUT)) dut_le (
        .clk(clk), .reset(reset), .start(start), .addr_in(addr_in),
        .busy(busy_le), .done(done_le), .err(err_le), .mem_req(req_le),
        .mem_addr(maddr_le), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .reg_data(rd_le), .reg_load(rl_le), .state_dbg(st_le)
    );

    mem_word_loader #(.DATAWIDTH(16), .BYTEWIDTH(8), .ADDRWIDTH(16),
                      .LITTLE_ENDIAN(0), .TIMEOUT(TIMEOUT)) dut_be (
        .clk(clk), .reset(reset), .start(start), .addr_in(addr_in),
        .busy(busy_be), .done(done_be), .err(err_be), .mem_req(req_be),
        .mem_addr(maddr_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .reg_data(rd_be), .reg_load(rl_be), .state_dbg(st_be)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [15:0] addr0;
        logic [15:0] addr1;
        logic        err;
        logic [15:0] word_le;
        logic [15:0] word_be;
        int          lat;
        int          rises;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  mem [0:65535];
    logic [15:0] model_le, model_be;
    int          total, bad;
    int          d0, d1;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int   rcnt, req_idx;
    logic prev_rq;
    initial begin
        mem_ack = 1'b0; mem_rdata = 8'h00; rcnt = 0; req_idx = 0; prev_rq = 1'b0;
    end
    always @(negedge clk) begin
        int dly;
        if (req_le) begin
            dly = (req_idx == 0) ? d0 : d1;
            if (rcnt == dly) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[maddr_le];
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 8'($urandom);
            end
            rcnt++;
        end else begin
            if (prev_rq) req_idx++;
            rcnt      = 0;
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 8'($urandom);
            if (!busy_le) req_idx = 0;
        end
        prev_rq = req_le;
    end

    // ---------------- monitor ----------------
    int   m_cyc, m_rises, m_gap, m_loads;
    logic m_prev;
    initial begin
        m_cyc = 0; m_rises = 0; m_gap = 0; m_loads = 0; m_prev = 1'b0;
    end
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            m_cyc = 0; m_rises = 0; m_gap = 0; m_loads = 0; m_prev = 1'b0;
        end else begin
            if (busy_le) m_cyc++;
            if (req_le && !m_prev) begin
                m_rises++;
                if (exp_q.size() == 0) begin
                    check("spurious_req", 1, 0);
                end else if (m_rises == 1) begin
                    check("addr_first", maddr_le, exp_q[0].addr0);
                    check("addr_first_be", maddr_be, exp_q[0].addr0);
                end else begin
                    check("addr_second", maddr_le, exp_q[0].addr1);
                    check("gap_len", m_gap, 1);
                end
            end
            if (!req_le && m_rises == 1) m_gap++;
            if (!rl_le || !rl_be) begin
                m_loads++;
                check("load_both", {31'd0, rl_be}, {31'd0, rl_le});
                if (exp_q.size() == 0) begin
                    check("spurious_load", 1, 0);
                end else begin
                    check("load_data_le", rd_le, exp_q[0].word_le);
                    check("load_data_be", rd_be, exp_q[0].word_be);
                end
            end
            if (err_le && !done_le) check("err_without_done", 0, 1);
            if (done_le || done_be) begin
                check("done_both", {31'd0, done_be}, {31'd0, done_le});
                if (exp_q.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("err_le", {31'd0, err_le}, {31'd0, e.err});
                    check("err_be", {31'd0, err_be}, {31'd0, e.err});
                    check("load_count", m_loads, e.err ? 0 : 1);
                    check("req_count", m_rises, e.rises);
                    check("latency", m_cyc, e.lat);
                    check("held_le", rd_le, e.word_le);
                    check("held_be", rd_be, e.word_be);
                    check("req_low_at_done", {31'd0, req_le}, 0);
                    check("load_high_at_done", {31'd0, rl_le}, 1);
                end
                m_cyc = 0; m_rises = 0; m_gap = 0; m_loads = 0;
            end
            m_prev = req_le;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_expect(input logic [15:0] a, input int dl0, input int dl1);
        exp_t e;
        logic [15:0] a1;
        a1 = a + 16'd1;
        e.addr0 = a;
        e.addr1 = a1;
        if (dl0 >= TIMEOUT) begin
            e.err = 1'b1; e.rises = 1; e.lat = TIMEOUT + 1;
        end else if (dl1 >= TIMEOUT) begin
            e.err = 1'b1; e.rises = 2; e.lat = dl0 + 1 + 1 + TIMEOUT + 1;
        end else begin
            e.err = 1'b0; e.rises = 2; e.lat = dl0 + dl1 + 5;
            model_le = {mem[a1], mem[a]};
            model_be = {mem[a], mem[a1]};
        end
        e.word_le = model_le;
        e.word_be = model_be;
        exp_q.push_back(e);
    endtask

    task automatic do_txn(input logic [15:0] a, input int dl0, input int dl1);
        int n;
        @(negedge clk);
        n = 0;
        while (busy_le && n < 100) begin @(negedge clk); n++; end
        if (busy_le) check("idle_wait_bound", 1, 0);
        d0 = dl0; d1 = dl1;
        push_expect(a, dl0, dl1);
        addr_in = a;
        start   = 1'b1;
        @(negedge clk);
        n = 0;
        // Random start pulses while busy must be ignored.
        while (busy_le && n < 400) begin
            start   = ($urandom_range(0, 3) == 0);
            addr_in = 16'($urandom);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (busy_le) check("txn_wait_bound", 1, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_busy"}, {31'd0, busy_le | busy_be}, 0);
        check({tag, "_done"}, {31'd0, done_le | done_be}, 0);
        check({tag, "_err"}, {31'd0, err_le | err_be}, 0);
        check({tag, "_req"}, {31'd0, req_le | req_be}, 0);
        check({tag, "_addr"}, maddr_le | maddr_be, 0);
        check({tag, "_data"}, rd_le | rd_be, 0);
        check({tag, "_load"}, {31'd0, rl_le & rl_be}, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        exp_t dummy;
        int   r, a0, b0;
        total = 0; bad = 0;
        reset = 1'b0; start = 1'b0; addr_in = 16'h0000; d0 = 0; d1 = 0;
        model_le = 16'h0000; model_be = 16'h0000;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1 check_reset_values("rst_init");
        @(negedge clk);
        reset = 1'b1;

        // Basic load, both byte orders
        mem[16'h0040] = 8'h34;
        mem[16'h0041] = 8'h12;
        do_txn(16'h0040, 0, 0);
        check("basic_le_word", rd_le, 16'h1234);
        check("basic_be_word", rd_be, 16'h3412);

        // Address wrap with wait states
        do_txn(16'hFFFF, 3, 3);

        // Timeouts and ack on the expiry cycle
        do_txn(16'($urandom), NEVER, 0);
        do_txn(16'($urandom), TIMEOUT - 1, 0);
        do_txn(16'($urandom), 0, TIMEOUT - 1);
        do_txn(16'($urandom), 2, NEVER);
        do_txn(16'($urandom), TIMEOUT, 0);

        // Reset while in FETCH1
        @(negedge clk);
        d0 = 0; d1 = NEVER;
        push_expect(16'h1230, 0, NEVER);
        addr_in = 16'h1230;
        start   = 1'b1;
        @(negedge clk);        // FETCH0
        start = 1'b0;
        @(negedge clk);        // GAP
        @(negedge clk);        // FETCH1
        @(negedge clk);        // FETCH1
        reset = 1'b0;
        @(posedge clk);
        #1 check_reset_values("rst_mid");
        while (exp_q.size() > 0) dummy = exp_q.pop_front();
        model_le = 16'h0000; model_be = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        check("post_reset_data", rd_le, 16'h0000);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            r  = $urandom_range(0, 9);
            a0 = (r == 0) ? NEVER : $urandom_range(0, 16);
            r  = $urandom_range(0, 9);
            b0 = (r == 0) ? NEVER : $urandom_range(0, 16);
            do_txn(16'($urandom), a0, b0);
        end

        repeat (5) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_word_loader.md
# mem_word_loader

Upstream feeder for the processor's DATAWIDTH-wide `Register` stages. It fetches one 16-bit word from the 8-bit-wide data memory as two byte reads over a req/ack handshake, then assembles the word. It presents the word on the register's DataIn and drives the register's active-low load for exactly one cycle. A timeout counter aborts a read when memory never acknowledges.

## Interface
- DATAWIDTH, 16, assembled word width; must equal 2*BYTEWIDTH
- BYTEWIDTH, 8, memory data width
- ADDRWIDTH, 16, byte address width
- LITTLE_ENDIAN, 1, 1: byte at addr is low byte; 0: byte at addr is high byte
- TIMEOUT, 15, cycles (≥1) to wait for mem_ack per byte before aborting
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset, synchronous, active-low
- start  in  1  request a word load; sampled only in IDLE
- addr_in  in  ADDRWIDTH  byte address of first byte; latched with start
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, when the read timed out
- mem_req  out  1  memory read request
- mem_addr  out  ADDRWIDTH  memory byte address
- mem_ack  in  1  memory acknowledge; mem_rdata valid in the same cycle
- mem_rdata  in  BYTEWIDTH  memory read data
- reg_data  out  DATAWIDTH  to Register DataIn; held between loads
- reg_load  out  1  to Register load, active-low

## Operation
- All outputs are registered.
- States: IDLE, FETCH0, GAP, FETCH1, LOAD, DONE.
- IDLE: on start=1, latch addr_in, set mem_addr=addr_in, mem_req=1, and go to FETCH0. start is ignored in every other state.
- FETCH0: hold mem_req=1 and mem_addr. On a rising edge with mem_ack=1, capture mem_rdata into byte0, set mem_req=0, set mem_addr=addr+1, and go to GAP.
- GAP: go to FETCH1 unconditionally with mem_req=1. This guarantees mem_req is low for at least one cycle between requests.
- FETCH1: on mem_ack=1, capture byte1, set mem_req=0, and go to LOAD. In the same edge, update reg_data and set reg_load=0.
  - LITTLE_ENDIAN=1: reg_data = {byte1, byte0}.
  - LITTLE_ENDIAN=0: reg_data = {byte0, byte1}.
- LOAD: reg_load is low for this one cycle. Go to DONE with reg_load=1 and done=1.
- DONE: go to IDLE with done=0.
- Address arithmetic is modulo 2^ADDRWIDTH: 0xFFFF+1 = 0x0000.
- Timeout:
  - The counter clears on entering FETCH0 or FETCH1 and increments each cycle spent in a FETCH state without mem_ack.
  - When it reaches TIMEOUT, go to DONE with done=1, err=1, mem_req=0. reg_load is never asserted and reg_data is unchanged.
  - If mem_ack=1 on the same edge the count would expire, the ack wins.
- mem_ack while mem_req=0 is ignored.
- Reset applies in any state, mid-operation included. The read is abandoned: no load pulse and no done.
- Reset values: state IDLE, busy=0, done=0, err=0, mem_req=0, mem_addr=0, reg_data=0, reg_load=1.

## Timing
- The Register samples on falling clk. reg_load and reg_data change only on rising edges, so both are stable across the falling edge inside the LOAD cycle.
- Minimum latency with mem_ack high at the first opportunity, where E0 is the edge sampling start:
  - FETCH0 after E0.
  - GAP after E1.
  - FETCH1 after E2.
  - LOAD after E3: reg_load low, reg_data valid.
  - DONE after E4: done=1.
  - IDLE after E5.
- Each cycle of ack delay adds one cycle.
- A new start is accepted in the cycle after DONE, at the earliest.
- busy is high from the cycle after start is sampled through the DONE cycle inclusive.
- reg_load is low for exactly one cycle per successful load and never during a timeout or reset.

## Test plan
- Basic load: LITTLE_ENDIAN=1, start with addr_in=0x0040, memory returns 0x34 then 0x12 with immediate ack.
  - mem_addr shows 0x0040 then 0x0041.
  - reg_data=0x1234 with reg_load low for one cycle after E3.
  - done pulses after E4, err=0.
- Big-endian: same stimulus with LITTLE_ENDIAN=0 -> reg_data=0x3412.
- Wrap and wait states: addr_in=0xFFFF, ack delayed 3 cycles per byte.
  - Second mem_addr=0x0000.
  - reg_load low exactly once.
  - mem_req low for exactly one cycle in GAP.
- Timeout: never ack.
  - After 15 FETCH0 cycles, done=1 and err=1 together.
  - mem_req drops, reg_load stays 1, reg_data unchanged.
  - Repeat with ack arriving on the expiry cycle -> ack wins and the load completes.
- Reset and busy handling:
  - Pull reset low during FETCH1 -> next edge: all outputs at reset values, no reg_load pulse, no done.
  - Pulse start while busy -> ignored; no second read is issued.
